// File: rtl/regctx_pkg.sv
// Shared types and index helpers for the register context save/restore sequencer.
package regctx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    FINISH
  } seq_state_e;

  localparam int IDX_W        = 5;
  localparam int ZERO_REG_IDX = 31;
  localparam int FP_REG_IDX   = 29;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             last;
  } next_idx_t;

  // Step past the hard-wired zero register; 'last' means the walk has run off the bank.
  function automatic next_idx_t next_idx(input logic [IDX_W-1:0] idx,
                                         input int zero_reg = ZERO_REG_IDX,
                                         input int num_regs = 32);
    int n;
    n = int'(idx) + 1;
    if (n == zero_reg) n = n + 1;
    next_idx.idx  = n[IDX_W-1:0];
    next_idx.last = (n >= num_regs);
  endfunction

endpackage

// File: rtl/reg_port_mux.sv
// Steers the register bank write port and read port 1 between the core and the sequencer.
module reg_port_mux
  import regctx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              seq_active,
  input  logic              core_reg_write,
  input  logic [ADDR_W-1:0] core_reg_escrita,
  input  logic [DATA_W-1:0] core_escreve_dado,
  input  logic [ADDR_W-1:0] core_reg1,
  input  logic              seq_reg_write,
  input  logic [ADDR_W-1:0] seq_idx,
  input  logic [DATA_W-1:0] seq_wdata,
  output logic              rf_reg_write,
  output logic [ADDR_W:0]   rf_reg_escrita,
  output logic [DATA_W-1:0] rf_escreve_dado,
  output logic [ADDR_W-1:0] rf_reg1
);

  always_comb begin
    rf_reg_write    = core_reg_write;
    rf_reg_escrita  = {1'b0, core_reg_escrita};
    rf_escreve_dado = core_escreve_dado;
    rf_reg1         = core_reg1;
    if (seq_active) begin
      rf_reg_write    = seq_reg_write;
      rf_reg_escrita  = {1'b0, seq_idx};
      rf_escreve_dado = seq_wdata;
      rf_reg1         = seq_idx;
    end
  end

endmodule

// File: rtl/reg_context_sequencer.sv
// Walks the register bank to save it to, or restore it from, a memory save area
// while stalling the core.
module reg_context_sequencer
  import regctx_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 5,
  parameter int          NUM_REGS  = 32,
  parameter int          ZERO_REG  = 31,
  parameter logic [31:0] SAVE_BASE = 32'h0000_0F80
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SaveReq,
  input  logic              RestoreReq,
  output logic              Busy,
  output logic              Done,
  output logic              CoreStall,
  input  logic              CoreRegWrite,
  input  logic [ADDR_W-1:0] CoreRegEscrita,
  input  logic [DATA_W-1:0] CoreEscreveDado,
  input  logic [ADDR_W-1:0] CoreReg1,
  output logic              RfRegWrite,
  output logic [ADDR_W:0]   RfRegEscrita,
  output logic [DATA_W-1:0] RfEscreveDado,
  output logic [ADDR_W-1:0] RfReg1,
  input  logic [DATA_W-1:0] RfDado1,
  output logic              MemReq,
  output logic              MemWe,
  output logic [31:0]       MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = (ZERO_REG == 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  next_idx_t         nxt;
  logic              seq_wr, mem_req, mem_we, done, mux_reg_write;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_wr  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    nxt     = next_idx(idx_q, ZERO_REG, NUM_REGS);
    case (state_q)
      IDLE: begin
        if (SaveReq) begin
          state_d = SAVE;
          idx_d   = FIRST_IDX;
        end else if (RestoreReq) begin
          state_d = RESTORE;
          idx_d   = FIRST_IDX;
        end
      end
      SAVE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (MemAck) begin
          if (nxt.last) state_d = FINISH;
          else          idx_d   = nxt.idx;
        end
      end
      RESTORE: begin
        mem_req = 1'b1;
        if (MemAck) begin
          // The zero register is never a write target, even if it sits inside the walk.
          seq_wr = (idx_q != ZERO_IDX);
          if (nxt.last) state_d = FINISH;
          else          idx_d   = nxt.idx;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  reg_port_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_port_mux (
    .seq_active       (state_q != IDLE),
    .core_reg_write   (CoreRegWrite),
    .core_reg_escrita (CoreRegEscrita),
    .core_escreve_dado(CoreEscreveDado),
    .core_reg1        (CoreReg1),
    .seq_reg_write    (seq_wr),
    .seq_idx          (idx_q),
    .seq_wdata        (MemRData),
    .rf_reg_write     (mux_reg_write),
    .rf_reg_escrita   (RfRegEscrita),
    .rf_escreve_dado  (RfEscreveDado),
    .rf_reg1          (RfReg1)
  );

  // Reset masks the control outputs in the same cycle, before the state register clears.
  assign Busy       = (state_q != IDLE) & ~Reset;
  assign CoreStall  = Busy;
  assign Done       = done & ~Reset;
  assign MemReq     = mem_req & ~Reset;
  assign RfRegWrite = mux_reg_write & ~Reset;
  assign MemWe      = mem_we;
  assign MemAddr    = SAVE_BASE + {{(30-ADDR_W){1'b0}}, idx_q, 2'b00};
  assign MemWData   = RfDado1;

endmodule

// File: doc/reg_context_sequencer.md
Name: reg_context_sequencer

Overview:
Sequences the 32x32 register bank for context save and restore on interrupt entry and exit. On a save request it walks every register except the hard-wired zero register and writes each one to a memory save area. On a restore request it reads the save area back into the bank. It sits between the core writeback/read path and the register bank. It owns the bank's write port and read port 1 while busy, and stalls the core for the duration.

Parameters:
DATA_W, 32, register and memory data width
ADDR_W, 5, register index width
NUM_REGS, 32, number of registers in the bank
ZERO_REG, 31, index of the $zero register; never written, never saved
SAVE_BASE, 32'h0000_0F80, byte address of the save area; register i lives at SAVE_BASE + 4*i

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
SaveReq  in  1  pulse; start context save
RestoreReq  in  1  pulse; start context restore
Busy  out  1  sequence in progress (state != IDLE)
Done  out  1  one-cycle pulse at end of a sequence
CoreStall  out  1  equals Busy; core must hold its pipeline
CoreRegWrite  in  1  core writeback enable
CoreRegEscrita  in  5  core writeback index
CoreEscreveDado  in  DATA_W  core writeback data
CoreReg1  in  5  core read index, port 1
RfRegWrite  out  1  to bank RegWrite
RfRegEscrita  out  6  to bank RegEscrita; bit 5 always 0
RfEscreveDado  out  DATA_W  to bank EscreveDado
RfReg1  out  5  to bank Reg1
RfDado1  in  DATA_W  from bank Dado1 (combinational read)
MemReq  out  1  memory request, held until acknowledged
MemWe  out  1  1 = write, 0 = read
MemAddr  out  32  byte address
MemWData  out  DATA_W  write data
MemRData  in  DATA_W  read data, valid when MemAck is high
MemAck  in  1  request accepted; may be high in the first MemReq cycle

Behaviour:
- States: IDLE, SAVE, RESTORE, FINISH. The state register and index register idx (ADDR_W bits) are registered.
- Reset behaviour:
  - State goes to IDLE and idx to 0.
  - Busy=0, Done=0, MemReq=0 and RfRegWrite=0 during any cycle Reset is high.
  - Reset mid-sequence abandons the sequence; MemReq drops at the next edge; no Done is issued.
- IDLE transitions:
  - SaveReq=1 -> SAVE. RestoreReq=1 -> RESTORE. Both high: SaveReq wins.
  - On entry, idx is set to the first index that is not ZERO_REG (0 with defaults).
- Requests: ignored while not in IDLE, with no queuing. In the accept cycle, core writeback still passes through to the bank.
- SAVE:
  - Outputs: RfReg1=idx, MemReq=1, MemWe=1, MemAddr=SAVE_BASE+{idx,2'b00}, MemWData=RfDado1.
  - On MemAck, advance idx to the next index that is not ZERO_REG. After the last valid index is acked, go to FINISH.
- RESTORE:
  - Outputs: MemReq=1, MemWe=0, MemAddr as in SAVE.
  - On MemAck in the same cycle: RfRegWrite=1, RfRegEscrita={1'b0,idx}, RfEscreveDado=MemRData; then advance idx as in SAVE.
- FINISH: Done=1 for one cycle, Busy=1, then go to IDLE.
- Memory handshake:
  - MemAddr, MemWe and MemWData stay stable while MemReq=1 and MemAck=0.
  - Wait states are unlimited; no timeout.
- Zero-wait throughput: one register per cycle. With defaults, 31 transfers, Busy high for 32 cycles including FINISH.
- Mux rules:
  - In IDLE, the Rf* outputs equal the Core* inputs; CoreRegEscrita is zero-extended to 6 bits.
  - When not in IDLE, core write inputs are ignored (RfRegWrite is driven only by the sequencer) and RfReg1=idx.
- ZERO_REG is never driven as a write target by the sequencer, even in RESTORE.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32.

Decomposition:
- Shared package regctx_pkg holds:
  - the state enum (IDLE, SAVE, RESTORE, FINISH);
  - ZERO_REG_IDX=31 and FP_REG_IDX=29;
  - the function next_idx(idx), which returns idx+1, or idx+2 when idx+1==ZERO_REG, plus a last-index flag.
- One sub-module, reg_port_mux, holds the combinational core/sequencer steering of the write port and read port 1.
- The FSM, idx counter and memory handshake stay in the top.

Test Plan:
- Bank preloaded r1=102, r2=54, r3=4, r4=10; SaveReq pulse; MemAck tied 1 -> 31 writes, with addresses 0xF80..0xFF8 skipping 0xFFC. Writes include 0xF84=102, 0xF88=54, 0xF8C=4, 0xF90=10. Done pulses on cycle 32 after the request; Busy drops on the following cycle.
- Memory model returns 0x100+i for address SAVE_BASE+4*i; RestoreReq -> r0..r30 read back as 0x100..0x11E, r31 remains 0, no write to index 31, Done once.
- MemAck delayed 3 cycles per request during save -> MemReq, MemAddr and MemWData held constant across wait cycles; total Busy = 31*4+1 cycles.
- SaveReq and RestoreReq asserted together in IDLE -> save sequence runs (MemWe=1); a RestoreReq raised mid-save has no effect.
- Core writes r5=0xDEAD with CoreRegWrite in the SaveReq cycle -> the write lands in the bank. The same write presented while Busy -> r5 unchanged, and CoreStall=1.
- Reset pulsed after the 10th acked save -> next cycle state IDLE, MemReq=0, Busy=0, no Done. A fresh SaveReq then restarts at address 0xF80.
